// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 VGA timing generator.
// The VGA_* values are the defaults; the top module derives its own geometry from its parameters.
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL  = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL  = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    localparam int CNT_W = $clog2(VGA_H_TOTAL);

    // {hsync_n, vsync_n, blank_n} with nothing being displayed
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth pipeline that lines the sync/blank terms up with pixel-memory read data.
// Reset and flush both load the idle pattern into every stage.
module vga_delay_line #(
    parameter int               DEPTH = 2,
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] IDLE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= IDLE;
            end
        end else begin
            stage[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: waits for a settled PLL lock, then issues pixel fetches
// and PIX_LAT-delayed sync/blank outputs.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   WAIT_LOCK | counters held at 0, outputs idle, waiting for locked_s
//   SETTLE    | locked_s must stay high for LOCK_WAIT cycles
//   RUN       | h/v counters free-running; any lock loss returns to WAIT_LOCK
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int LOCK_WAIT = 16,
    parameter int PIX_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       running,
    output logic       rd_en,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0]       SETTLE_LAST = 8'(LOCK_WAIT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] h_cnt, h_nx;
    logic [CNT_W-1:0] v_cnt, v_nx;
    logic [7:0]       settle_cnt, settle_nx;
    logic             sync_meta, locked_s;
    logic             hsync_raw, vsync_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            h_cnt      <= '0;
            v_cnt      <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            h_cnt      <= h_nx;
            v_cnt      <= v_nx;
            settle_cnt <= settle_nx;
        end
    end

    // Counters default to zero so every exit from RUN drops the partial frame.
    always_comb begin
        state_nx  = state;
        h_nx      = '0;
        v_nx      = '0;
        settle_nx = '0;
        unique case (state)
            WAIT_LOCK: begin
                if (locked_s) state_nx = SETTLE;
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx = RUN;
                end else begin
                    settle_nx = settle_cnt + 8'd1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                end else if (h_cnt == H_LAST) begin
                    v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_nx = h_cnt + 1'b1;
                    v_nx = v_cnt;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    assign running     = (state == RUN);
    assign rd_en       = running && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign x           = rd_en ? h_cnt : '0;
    assign y           = rd_en ? v_cnt[8:0] : '0;
    assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);
    assign hsync_raw   = !(running && (h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync_raw   = !(running && (v_cnt >= VS_START) && (v_cnt < VS_END));

    // Held flushed outside RUN: the tail of an interrupted line is dropped,
    // so the delayed outputs are idle from the second cycle after RUN exit.
    vga_delay_line #(
        .DEPTH (PIX_LAT),
        .WIDTH (3),
        .IDLE  (SYNC_IDLE)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush   (!running),
        .sample  ({hsync_raw, vsync_raw, rd_en}),
        .delayed ({hsync_n, vsync_n, blank_n})
    );

endmodule
